// File: rtl/mdr_mem_interface_if.sv
// Memory-side handshake bundle between the MDR/MAR stage (master) and external memory (slave).
interface mdr_mem_interface_if #(
  parameter int ADDR_W = 9
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mdr_mem_interface.sv
// MAR/MDR capture from the bus mux plus a handshaked memory read/write engine with
// a wait-cycle timeout that aborts transactions the memory never acknowledges.
module mdr_mem_interface #(
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         BusMuxOut,
  input  logic                MARin,
  input  logic                MDRin,
  input  logic                Read,
  input  logic                rd_req,
  input  logic                wr_req,
  output logic [31:0]         MDRout_data,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  mdr_mem_interface_if.master mem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] WR_WAIT = 2'd2;

  logic [1:0]        state_r, state_s;
  logic [ADDR_W-1:0] mar_r, mar_s;
  logic [31:0]       mdr_r, mdr_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              done_r, done_s;
  logic              err_r, err_s;
  logic              mem_rd_r, mem_wr_r, busy_r;

  // Next-state, register-load and completion/abort decisions
  always_comb begin
    state_s = state_r;
    mar_s   = mar_r;
    mdr_s   = mdr_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    err_s   = err_r;
    case (state_r)
      IDLE: begin
        if (MARin) begin
          mar_s = BusMuxOut[ADDR_W-1:0];
        end else begin
          mar_s = mar_r;
        end
        if (MDRin) begin
          mdr_s = Read ? mem.mem_rdata : BusMuxOut;
        end else begin
          mdr_s = mdr_r;
        end
        // Read wins; a simultaneous write request is simply dropped
        if (rd_req) begin
          state_s = RD_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else if (wr_req) begin
          state_s = WR_WAIT;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        // Ack is checked first so an ack on the timeout edge still completes
        if (mem.mem_ack) begin
          if (state_r == RD_WAIT) begin
            mdr_s = mem.mem_rdata;
          end else begin
            mdr_s = mdr_r;
          end
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (cnt_r == TIMEOUT_C) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; strobes are registered from the next state
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r  <= IDLE;
      mar_r    <= {ADDR_W{1'b0}};
      mdr_r    <= 32'd0;
      cnt_r    <= {CNT_W{1'b0}};
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      mar_r    <= mar_s;
      mdr_r    <= mdr_s;
      cnt_r    <= cnt_s;
      done_r   <= done_s;
      err_r    <= err_s;
      mem_rd_r <= (state_s == RD_WAIT);
      mem_wr_r <= (state_s == WR_WAIT);
      busy_r   <= (state_s != IDLE);
    end
  end

  assign MDRout_data   = mdr_r;
  assign mem.mem_addr  = mar_r;
  assign mem.mem_wdata = mdr_r;
  assign mem.mem_rd    = mem_rd_r;
  assign mem.mem_wr    = mem_wr_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign timeout_err   = err_r;

endmodule
